imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 124 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV immediate generator feeding a 2-entry valid/ready FIFO with a sideband tag.
// Optional macro IMMGEN_FULL_OFFSET_EN: B/J immediates as byte offsets (default: halfword units).
module imm_gen_pipe #(
    parameter int XLEN = 64,
    parameter int TAGW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [TAGW-1:0] out_tag,
    output logic [15:0]     inv_cnt
);

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_Z    = 3'd5,
        FMT_NONE = 3'd6,
        FMT_INV  = 3'd7
    } fmt_t;

    function automatic fmt_t decode_fmt(input logic [31:0] inst);
        fmt_t f;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b0001111: f = FMT_I;
            7'b0100011:             f = FMT_S;
            7'b1100011:             f = FMT_B;
            7'b0110111, 7'b0010111: f = FMT_U;
            7'b1101111:             f = FMT_J;
            7'b1110011:             f = inst[14] ? FMT_Z : FMT_I;
            7'b0110011, 7'b0111011: f = FMT_NONE;
            default:                f = FMT_INV;
        endcase
        return f;
    endfunction

    // Every format fits in 32 signed bits, so build it there and widen once to XLEN.
    function automatic logic signed [31:0] decode_imm32(input logic [31:0] inst, input fmt_t f);
        logic signed [31:0] v;
        case (f)
            FMT_I: v = {{20{inst[31]}}, inst[31:20]};
            FMT_S: v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
`ifdef IMMGEN_FULL_OFFSET_EN
            FMT_B: v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_J: v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`else
            FMT_B: v = {{20{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8]};
            FMT_J: v = {{12{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21]};
`endif
            FMT_U: v = {inst[31:12], 12'b0};
            FMT_Z: v = {27'b0, inst[19:15]};
            default: v = 32'sd0;
        endcase
        return v;
    endfunction

    fmt_t               w_fmt;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic               w_push;
    logic               w_pop;

    logic [XLEN-1:0]    r_imm [2];
    logic [2:0]         r_fmt [2];
    logic [TAGW-1:0]    r_tag [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;
    logic [15:0]        r_invCnt;

    assign w_fmt   = decode_fmt(in_inst);
    assign w_imm32 = decode_imm32(in_inst, w_fmt);
    assign w_imm   = XLEN'(w_imm32);

    // Readiness comes from registered occupancy only, never from out_ready.
    assign in_ready  = (r_count != 2'd2) && !rst;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_imm = r_imm[r_rptr];
    assign out_fmt = r_fmt[r_rptr];
    assign out_tag = r_tag[r_rptr];
    assign inv_cnt = r_invCnt;

    // Storage is cleared on reset so the idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_imm[i] <= '0;
                r_fmt[i] <= '0;
                r_tag[i] <= '0;
            end
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_invCnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_imm[r_wptr] <= w_imm;
                r_fmt[r_wptr] <= w_fmt;
                r_tag[r_wptr] <= in_tag;
                r_wptr        <= ~r_wptr;
                if (w_fmt == FMT_INV && r_invCnt != 16'hFFFF)
                    r_invCnt <= r_invCnt + 16'd1;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed self-checking bench for imm_gen_pipe (XLEN=64, TAGW=64).
module tb_imm_gen_pipe;

    localparam int XLEN = 64;
    localparam int TAGW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [TAGW-1:0] out_tag;
    logic [15:0]     inv_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0]     imm;
        logic [2:0]      fmt;
        logic [TAGW-1:0] tag;
    } entry_t;

    entry_t q[$];

    imm_gen_pipe #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_tag(out_tag), .inv_cnt(inv_cnt)
    );

    always #5 clk = ~clk;

    // Reference: assemble each immediate as an integer value, then apply its sign weight.
    function automatic void ref_decode(input logic [31:0] ins, output logic [63:0] imm, output logic [2:0] fmt);
        longint v;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F: fmt = 3'd0;
            7'h23: fmt = 3'd1;
            7'h63: fmt = 3'd2;
            7'h37, 7'h17: fmt = 3'd3;
            7'h6F: fmt = 3'd4;
            7'h73: fmt = ins[14] ? 3'd5 : 3'd0;
            7'h33, 7'h3B: fmt = 3'd6;
            default: fmt = 3'd7;
        endcase
        v = 0;
        case (fmt)
            3'd0: begin
                v = longint'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
            3'd1: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            3'd2: begin
`ifdef IMMGEN_FULL_OFFSET_EN
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v -= 4096;
`else
                v = longint'(ins[7]) * 1024 + longint'(ins[30:25]) * 16 + longint'(ins[11:8]);
                if (ins[31]) v -= 2048;
`endif
            end
            3'd3: begin
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v -= 64'sh1_0000_0000;
            end
            3'd4: begin
`ifdef IMMGEN_FULL_OFFSET_EN
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v -= 1048576;
`else
                v = longint'(ins[19:12]) * 2048 + longint'(ins[20]) * 1024 + longint'(ins[30:21]);
                if (ins[31]) v -= 524288;
`endif
            end
            3'd5: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        imm = 64'(v);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_inst = 32'h0000_0000;
        in_tag = 64'hDEAD_BEEF_0000_0001;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_in_ready_low got %b want 0", in_ready);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_imm !== '0 || out_fmt !== 3'd0 || out_tag !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state got v=%b imm=%h fmt=%0d tag=%h rdy=%b want 0/0/0/0/1",
                     out_valid, out_imm, out_fmt, out_tag, in_ready);
        end
        checks++;
        if (inv_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_inv_cnt got %h want 0000", inv_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ignored_input got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] insts [8];
        logic [63:0] imms  [8];
        logic [2:0]  fmts  [8];
        logic [15:0] invs  [8];
        logic [63:0] tag;
        insts = '{32'hFFF00093, 32'h800000B7, 32'hFE000EE3, 32'h0080006F,
                  32'h00000000, 32'h0000E073, 32'h0000A073, 32'h00000033};
`ifdef IMMGEN_FULL_OFFSET_EN
        imms  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8,
                  64'd0, 64'd1, 64'd0, 64'd0};
`else
        imms  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd4,
                  64'd0, 64'd1, 64'd0, 64'd0};
`endif
        fmts  = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd7, 3'd5, 3'd0, 3'd6};
        invs  = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tag = {$urandom, $urandom};
            in_valid = 1'b1;
            in_inst = insts[i];
            in_tag = tag;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_imm !== imms[i] || out_fmt !== fmts[i] || out_tag !== tag) begin
                errors++;
                $display("[TB] FAIL directed_%h got v=%b imm=%h fmt=%0d tag=%h want 1 %h %0d %h",
                         insts[i], out_valid, out_imm, out_fmt, out_tag, imms[i], fmts[i], tag);
            end
            checks++;
            if (inv_cnt !== invs[i]) begin
                errors++;
                $display("[TB] FAIL directed_inv_cnt_%h got %h want %h", insts[i], inv_cnt, invs[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_drain_%h got out_valid=%b want 0", insts[i], out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] tags [3];
        for (int i = 0; i < 3; i++) tags[i] = {$urandom, $urandom};
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'h00500093;
        in_tag = tags[0];
        @(posedge clk);
        #1;
        in_inst = 32'h00600113;
        in_tag = tags[1];
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_full_in_ready got %b want 0", in_ready);
        end
        in_inst = 32'h00700193;
        in_tag = tags[2];
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== tags[0] || out_imm !== 64'd5) begin
            errors++;
            $display("[TB] FAIL b2b_hold got rdy=%b v=%b tag=%h imm=%h want 0 1 %h 5",
                     in_ready, out_valid, out_tag, out_imm, tags[0]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_tag !== tags[1] || out_imm !== 64'd6 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second got tag=%h imm=%h rdy=%b want %h 6 1", out_tag, out_imm, in_ready, tags[1]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== tags[2] || out_imm !== 64'd7) begin
            errors++;
            $display("[TB] FAIL b2b_third got v=%b tag=%h imm=%h want 1 %h 7", out_valid, out_tag, out_imm, tags[2]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_empty got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [6:0]  opcodes [12];
        logic [15:0] expInv;
        logic        acc;
        logic        pop;
        entry_t      e;
        opcodes = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
        do_reset();
        q.delete();
        expInv = 16'd0;
        for (int c = 0; c < 600; c++) begin
            checks++;
            if (out_valid !== (q.size() > 0)) begin
                errors++;
                $display("[TB] FAIL rand_out_valid cyc %0d got %b want %b", c, out_valid, q.size() > 0);
            end
            checks++;
            if (in_ready !== (q.size() < 2)) begin
                errors++;
                $display("[TB] FAIL rand_in_ready cyc %0d got %b want %b", c, in_ready, q.size() < 2);
            end
            if (q.size() > 0) begin
                checks++;
                if (out_imm !== q[0].imm || out_fmt !== q[0].fmt || out_tag !== q[0].tag) begin
                    errors++;
                    $display("[TB] FAIL rand_head cyc %0d got imm=%h fmt=%0d tag=%h want %h %0d %h",
                             c, out_imm, out_fmt, out_tag, q[0].imm, q[0].fmt, q[0].tag);
                end
            end
            checks++;
            if (inv_cnt !== expInv) begin
                errors++;
                $display("[TB] FAIL rand_inv_cnt cyc %0d got %h want %h", c, inv_cnt, expInv);
            end
            in_valid = ($urandom_range(0, 3) != 0);
            in_inst = $urandom;
            if ($urandom_range(0, 3) != 0)
                in_inst[6:0] = opcodes[$urandom_range(0, 11)];
            in_tag = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && (q.size() < 2);
            pop = out_ready && (q.size() > 0);
            ref_decode(in_inst, e.imm, e.fmt);
            e.tag = in_tag;
            @(posedge clk);
            #1;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                if (e.fmt == 3'd7 && expInv != 16'hFFFF) expInv++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_inv_saturate();
        do_reset();
        in_valid = 1'b1;
        in_inst = 32'h0000_0000;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (inv_cnt !== 16'hFFFE) begin
            errors++;
            $display("[TB] FAIL inv_near_sat got %h want fffe", inv_cnt);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (inv_cnt !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL inv_saturated got %h want ffff", inv_cnt);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'h0000_0000;
        in_tag = 64'h1234;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || inv_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL midrst_preload got v=%b inv=%h want 1 0002", out_valid, inv_cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || inv_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midrst_flush got v=%b rdy=%b inv=%h want 0 1 0000", out_valid, in_ready, inv_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_inst = '0;
        in_tag = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_inv_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
